// File: rtl/flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : flow_ctrl
// Description : Pipeline stall/flush/redirect controller for the 5-stage core,
//               with a bus-wait watchdog, a multi-cycle EX hold and trap entry.
//               Optional performance counters: define FC_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module flow_ctrl #(
    parameter int BUS_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_load_use_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        ex_busy_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    input  logic        trap_req_i,
    input  logic [31:0] trap_vec_i,
    output logic        fc_stall_pc_o,
    output logic        fc_stall_ifid_o,
    output logic        fc_stall_idex_o,
    output logic        fc_stall_exmem_o,
    output logic        fc_stall_memwb_o,
    output logic        fc_flush_ifid_o,
    output logic        fc_flush_idex_o,
    output logic        fc_flush_exmem_o,
    output logic        fc_flush_memwb_o,
    output logic        fc_jump_flag_o,
    output logic [31:0] fc_jump_addr_o,
    output logic        fc_bus_err_o,
    output logic [1:0]  fc_state_o
`ifdef FC_PERF_CNT_EN
    ,
    output logic [31:0] fc_stall_cnt_o,
    output logic [31:0] fc_flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_EX_WAIT  = 2'd2,
        ST_TRAP     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(BUS_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [31:0]       r_trap_addr;
    logic [31:0]       w_trap_addr_nxt;
    logic              w_mem_wait;
    logic              w_trap_take;

    assign w_mem_wait  = mem_req_i & ~mem_ready_i;
    // A pending bus access blocks trap entry until it completes.
    assign w_trap_take = trap_req_i & ~((r_state == ST_MEM_WAIT) & w_mem_wait);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_trap_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_trap_addr <= w_trap_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = '0;
        w_trap_addr_nxt  = r_trap_addr;
        fc_stall_pc_o    = 1'b0;
        fc_stall_ifid_o  = 1'b0;
        fc_stall_idex_o  = 1'b0;
        fc_stall_exmem_o = 1'b0;
        fc_stall_memwb_o = 1'b0;
        fc_flush_ifid_o  = 1'b0;
        fc_flush_idex_o  = 1'b0;
        fc_flush_exmem_o = 1'b0;
        fc_flush_memwb_o = 1'b0;
        fc_jump_flag_o   = 1'b0;
        fc_jump_addr_o   = '0;
        fc_bus_err_o     = 1'b0;

        if (r_state == ST_TRAP) begin
            fc_jump_flag_o   = 1'b1;
            fc_jump_addr_o   = r_trap_addr;
            fc_flush_ifid_o  = 1'b1;
            fc_flush_idex_o  = 1'b1;
            fc_flush_exmem_o = 1'b1;
            w_state_nxt      = ST_IDLE;
        end else if (w_trap_take) begin
            fc_flush_ifid_o  = 1'b1;
            fc_flush_idex_o  = 1'b1;
            fc_flush_exmem_o = 1'b1;
            fc_flush_memwb_o = 1'b1;
            w_trap_addr_nxt  = trap_vec_i;
            w_state_nxt      = ST_TRAP;
        end else if (w_mem_wait) begin
            if (r_cnt == c_timeout_last) begin
                fc_bus_err_o     = 1'b1;
                fc_flush_ifid_o  = 1'b1;
                fc_flush_idex_o  = 1'b1;
                fc_flush_exmem_o = 1'b1;
                fc_flush_memwb_o = 1'b1;
                w_trap_addr_nxt  = trap_vec_i;
                w_state_nxt      = ST_TRAP;
            end else begin
                // Bubble into WB so the held MEM instruction is not retired twice.
                fc_stall_pc_o    = 1'b1;
                fc_stall_ifid_o  = 1'b1;
                fc_stall_idex_o  = 1'b1;
                fc_stall_exmem_o = 1'b1;
                fc_flush_memwb_o = 1'b1;
                w_cnt_nxt        = r_cnt + 1'b1;
                w_state_nxt      = ST_MEM_WAIT;
            end
        end else if (ex_busy_i) begin
            fc_stall_pc_o    = 1'b1;
            fc_stall_ifid_o  = 1'b1;
            fc_stall_idex_o  = 1'b1;
            fc_flush_exmem_o = 1'b1;
            w_state_nxt      = ST_EX_WAIT;
        end else begin
            w_state_nxt = ST_IDLE;
            if (ex_jump_i) begin
                // The squashed ID instruction makes any load-use hazard moot.
                fc_jump_flag_o  = 1'b1;
                fc_jump_addr_o  = ex_jump_addr_i;
                fc_flush_ifid_o = 1'b1;
                fc_flush_idex_o = 1'b1;
            end else if (id_load_use_i) begin
                fc_stall_pc_o   = 1'b1;
                fc_stall_ifid_o = 1'b1;
                fc_flush_idex_o = 1'b1;
            end
        end

        // Controls stay quiet while reset is held, whatever the inputs do.
        if (!rst_n) begin
            fc_stall_pc_o    = 1'b0;
            fc_stall_ifid_o  = 1'b0;
            fc_stall_idex_o  = 1'b0;
            fc_stall_exmem_o = 1'b0;
            fc_stall_memwb_o = 1'b0;
            fc_flush_ifid_o  = 1'b0;
            fc_flush_idex_o  = 1'b0;
            fc_flush_exmem_o = 1'b0;
            fc_flush_memwb_o = 1'b0;
            fc_jump_flag_o   = 1'b0;
            fc_jump_addr_o   = '0;
            fc_bus_err_o     = 1'b0;
        end
    end

    assign fc_state_o = r_state;

`ifdef FC_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (fc_stall_pc_o) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (fc_jump_flag_o) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign fc_stall_cnt_o = r_stall_cnt;
    assign fc_flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_flow_ctrl
// Description : Directed scoreboard bench for flow_ctrl (optionally with
//               FC_PERF_CNT_EN defined for the counter checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_ctrl;

    typedef struct packed {
        logic [4:0]  st;   // pc, ifid, idex, exmem, memwb
        logic [3:0]  fl;   // ifid, idex, exmem, memwb
        logic        jf;
        logic [31:0] ja;
        logic        err;
        logic [1:0]  sta;
    } exp_t;

    localparam logic [31:0] c_jaddr = 32'h8000_0040;
    localparam logic [31:0] c_tvec  = 32'h0000_0100;
    localparam logic [4:0]  c_s_mem = 5'b11110;
    localparam logic [4:0]  c_s_ex  = 5'b11100;
    localparam logic [4:0]  c_s_lu  = 5'b11000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_load_use_i = 1'b0;
    logic        ex_jump_i = 1'b0;
    logic [31:0] ex_jump_addr_i = c_jaddr;
    logic        ex_busy_i = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        trap_req_i = 1'b0;
    logic [31:0] trap_vec_i = c_tvec;
    logic        fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o;
    logic        fc_stall_exmem_o, fc_stall_memwb_o;
    logic        fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o;
    logic        fc_jump_flag_o;
    logic [31:0] fc_jump_addr_o;
    logic        fc_bus_err_o;
    logic [1:0]  fc_state_o;
`ifdef FC_PERF_CNT_EN
    logic [31:0] fc_stall_cnt_o, fc_flush_cnt_o;
    logic [31:0] snap_stall, snap_flush;
`endif

    always #5 clk = ~clk;

    flow_ctrl #(.BUS_TIMEOUT(16), .CNT_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_load_use_i    (id_load_use_i),
        .ex_jump_i        (ex_jump_i),
        .ex_jump_addr_i   (ex_jump_addr_i),
        .ex_busy_i        (ex_busy_i),
        .mem_req_i        (mem_req_i),
        .mem_ready_i      (mem_ready_i),
        .trap_req_i       (trap_req_i),
        .trap_vec_i       (trap_vec_i),
        .fc_stall_pc_o    (fc_stall_pc_o),
        .fc_stall_ifid_o  (fc_stall_ifid_o),
        .fc_stall_idex_o  (fc_stall_idex_o),
        .fc_stall_exmem_o (fc_stall_exmem_o),
        .fc_stall_memwb_o (fc_stall_memwb_o),
        .fc_flush_ifid_o  (fc_flush_ifid_o),
        .fc_flush_idex_o  (fc_flush_idex_o),
        .fc_flush_exmem_o (fc_flush_exmem_o),
        .fc_flush_memwb_o (fc_flush_memwb_o),
        .fc_jump_flag_o   (fc_jump_flag_o),
        .fc_jump_addr_o   (fc_jump_addr_o),
        .fc_bus_err_o     (fc_bus_err_o),
        .fc_state_o       (fc_state_o)
`ifdef FC_PERF_CNT_EN
        ,
        .fc_stall_cnt_o   (fc_stall_cnt_o),
        .fc_flush_cnt_o   (fc_flush_cnt_o)
`endif
    );

    exp_t q[$];
    int   nvec  = 0;
    int   nfail = 0;

    function automatic exp_t mk(input logic [4:0] st, input logic [3:0] fl,
                                input logic jf, input logic [31:0] ja,
                                input logic err, input logic [1:0] sta);
        exp_t e;
        e.st = st; e.fl = fl; e.jf = jf; e.ja = ja; e.err = err; e.sta = sta;
        return e;
    endfunction

    function automatic exp_t quiet(input logic [1:0] sta);
        return mk(5'b0, 4'b0, 1'b0, 32'h0, 1'b0, sta);
    endfunction

    // One clock: drive after the rising edge, queue the expectation, sample on the falling edge.
    task automatic cyc(input string tag, input logic rn, input logic lu, input logic jmp,
                       input logic busy, input logic mreq, input logic mrdy,
                       input logic trap, input exp_t e);
        exp_t got, want;
        @(posedge clk);
        #1;
        rst_n = rn; id_load_use_i = lu; ex_jump_i = jmp; ex_busy_i = busy;
        mem_req_i = mreq; mem_ready_i = mrdy; trap_req_i = trap;
        q.push_back(e);
        @(negedge clk);
        got = mk({fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o, fc_stall_memwb_o},
                 {fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o},
                 fc_jump_flag_o, fc_jump_addr_o, fc_bus_err_o, fc_state_o);
        want = q.pop_front();
        nvec++;
        assert (got === want) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

`ifdef FC_PERF_CNT_EN
    task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //         tag          rn lu jmp bsy mrq mrd trp
        cyc("reset",       0, 0, 0, 0, 0, 0, 0, quiet(2'd0));
`ifdef FC_PERF_CNT_EN
        chk_cnt("rst_stall_cnt", fc_stall_cnt_o, 32'd0);
        chk_cnt("rst_flush_cnt", fc_flush_cnt_o, 32'd0);
`endif
        cyc("idle0",       1, 0, 0, 0, 0, 0, 0, quiet(2'd0));
        cyc("load_use",    1, 1, 0, 0, 0, 0, 0, mk(c_s_lu, 4'b0100, 0, 0, 0, 2'd0));
        cyc("lu_release",  1, 0, 0, 0, 0, 0, 0, quiet(2'd0));
        cyc("lu_and_jump", 1, 1, 1, 0, 0, 0, 0, mk(5'b0, 4'b1100, 1, c_jaddr, 0, 2'd0));
        cyc("idle1",       1, 0, 0, 0, 0, 0, 0, quiet(2'd0));

        for (int i = 1; i <= 3; i++)
            cyc($sformatf("memwait%0d", i), 1, 0, 0, 0, 1, 0, 0,
                mk(c_s_mem, 4'b0001, 0, 0, 0, (i == 1) ? 2'd0 : 2'd1));
        cyc("mem_ready",   1, 0, 0, 0, 1, 1, 0, quiet(2'd1));
        cyc("mem_done",    1, 0, 0, 0, 0, 0, 0, quiet(2'd0));

        for (int i = 1; i <= 15; i++)
            cyc($sformatf("tmo_wait%0d", i), 1, 0, 0, 0, 1, 0, 0,
                mk(c_s_mem, 4'b0001, 0, 0, 0, (i == 1) ? 2'd0 : 2'd1));
        cyc("tmo_err",     1, 0, 0, 0, 1, 0, 0, mk(5'b0, 4'b1111, 0, 0, 1, 2'd1));
        cyc("tmo_trap",    1, 0, 0, 0, 1, 0, 0, mk(5'b0, 4'b1110, 1, c_tvec, 0, 2'd3));
        cyc("tmo_after",   1, 0, 0, 0, 0, 0, 0, quiet(2'd0));

        for (int i = 1; i <= 5; i++)
            cyc($sformatf("rstw_wait%0d", i), 1, 0, 0, 0, 1, 0, 0,
                mk(c_s_mem, 4'b0001, 0, 0, 0, (i == 1) ? 2'd0 : 2'd1));
        cyc("rst_midwait", 0, 0, 0, 0, 1, 0, 0, quiet(2'd0));
        cyc("rst_hold",    0, 0, 0, 0, 1, 0, 0, quiet(2'd0));
        cyc("rst_release", 1, 0, 0, 0, 0, 0, 0, quiet(2'd0));
        for (int i = 1; i <= 12; i++)
            cyc($sformatf("postrst_wait%0d", i), 1, 0, 0, 0, 1, 0, 0,
                mk(c_s_mem, 4'b0001, 0, 0, 0, (i == 1) ? 2'd0 : 2'd1));
        cyc("postrst_rdy", 1, 0, 0, 0, 1, 1, 0, quiet(2'd1));
        cyc("idle2",       1, 0, 0, 0, 0, 0, 0, quiet(2'd0));

`ifdef FC_PERF_CNT_EN
        snap_stall = fc_stall_cnt_o;
`endif
        for (int i = 1; i <= 4; i++)
            cyc($sformatf("exbusy%0d", i), 1, 0, 1, 1, 0, 0, 0,
                mk(c_s_ex, 4'b0010, 0, 0, 0, (i == 1) ? 2'd0 : 2'd2));
        cyc("ex_jump",     1, 0, 1, 0, 0, 0, 0, mk(5'b0, 4'b1100, 1, c_jaddr, 0, 2'd2));
        cyc("ex_after",    1, 0, 0, 0, 0, 0, 0, quiet(2'd0));
`ifdef FC_PERF_CNT_EN
        chk_cnt("stall_cnt_ex", fc_stall_cnt_o - snap_stall, 32'd4);
`endif

        cyc("pre_busy",    1, 0, 0, 1, 0, 0, 0, mk(c_s_ex, 4'b0010, 0, 0, 0, 2'd0));
        cyc("mem_preempt", 1, 0, 0, 1, 1, 0, 0, mk(c_s_mem, 4'b0001, 0, 0, 0, 2'd2));
        cyc("preempt_rdy", 1, 0, 0, 1, 1, 1, 0, mk(c_s_ex, 4'b0010, 0, 0, 0, 2'd1));
        cyc("busy_done",   1, 0, 0, 0, 0, 0, 0, quiet(2'd2));
        cyc("idle3",       1, 0, 0, 0, 0, 0, 0, quiet(2'd0));

`ifdef FC_PERF_CNT_EN
        snap_flush = fc_flush_cnt_o;
`endif
        cyc("trap_entry",  1, 0, 1, 0, 0, 0, 1, mk(5'b0, 4'b1111, 0, 0, 0, 2'd0));
        cyc("trap_state",  1, 0, 0, 0, 0, 0, 1, mk(5'b0, 4'b1110, 1, c_tvec, 0, 2'd3));
        cyc("trap_after",  1, 0, 0, 0, 0, 0, 0, quiet(2'd0));
`ifdef FC_PERF_CNT_EN
        chk_cnt("flush_cnt_trap", fc_flush_cnt_o - snap_flush, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
